uc_multiciclo: RTL and testbench

- Control unit for the simple CPU datapath (microc). Consumes the datapath's Opcode and z flag and drives s_inc, s_inm, we3, wez and Op.
- Runs a two-phase instruction cycle (FETCH, EXEC) with a PC enable, so each instruction takes exactly 2 clocks.
- Adds start/halt sequencing, an illegal-opcode trap and a retired-instruction counter for debug and verification.

---
 rtl/uc_multiciclo.sv | 62 ++++++
 tb/tb_uc_multiciclo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo.sv
// uc_multiciclo: two-phase (FETCH/EXEC) control unit for microc with start/halt, illegal-opcode trap and retired counter
module uc_multiciclo #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [5:0]       Opcode,
  input  logic             z,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALT, TRAP} state_t;
  state_t           state_q, state_d;
  logic [5:0]       ir_q;
  logic [CNT_W-1:0] retired_q;
  logic             op_ok, exec, is_li;
  always_comb op_ok = Opcode[5] || Opcode == 6'b000000 || Opcode[5:2] == 4'b0001 ||
                      Opcode == 6'b010000 || Opcode == 6'b010001 || Opcode == 6'b010010;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALT: state_d = start ? FETCH : state_q;
      FETCH:      state_d = op_ok ? EXEC : TRAP;
      EXEC:       state_d = halt_req ? HALT : FETCH;
      default:    state_d = TRAP;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) ir_q <= Opcode;
      if (state_q == EXEC) retired_q <= retired_q + 1'b1;
    end
  end
  // Undefined opcodes never reach EXEC, so decode only distinguishes legal classes
  always_comb begin
    exec  = state_q == EXEC;
    is_li = ir_q[5:2] == 4'b0001;
    s_inc = exec && (ir_q == 6'b010000 ? 1'b0 : ir_q == 6'b010001 ? ~z : ir_q == 6'b010010 ? z : 1'b1);
    s_inm = exec && is_li;
    we3   = exec && (ir_q[5] || is_li);
    wez   = exec && (ir_q[5] || is_li);
    Op    = exec && ir_q[5] ? ir_q[4:2] : 3'b000;
    pc_en = exec;
    busy  = state_q == FETCH || exec;
    err   = state_q == TRAP;
  end
  assign retired = retired_q;
endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo: scoreboard bench for uc_multiciclo (CNT_W=4 to exercise counter wrap)
module tb_uc_multiciclo;
  localparam int CNT_W = 4;
  logic clk = 0, reset = 0, start = 0, halt_req = 0, z = 0;
  logic [5:0] Opcode = '0;
  logic s_inc, s_inm, we3, wez, pc_en, busy, err;
  logic [2:0] Op;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] exp_ret = '0;
  logic [6:0] sb_q[$];
  int n_chk = 0, n_fail = 0;

  uc_multiciclo #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .Opcode(Opcode), .z(z),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op), .pc_en(pc_en),
    .busy(busy), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] model(input logic [5:0] op, input logic zv);
    if (op[5]) return {4'b1011, op[4:2]};
    if (op == 6'b000000) return 7'b1000_000;
    if (op[5:2] == 4'b0001) return 7'b1111_000;
    if (op == 6'b010001) return {~zv, 6'b0};
    if (op == 6'b010010) return {zv, 6'b0};
    return 7'b0;
  endfunction

  // Called with the DUT in FETCH; leaves it in FETCH (or HALT when hlt=1)
  task automatic run_instr(input logic [5:0] op, input logic zv, input logic hlt);
    int n;
    logic [6:0] e;
    Opcode = op;
    z = zv;
    sb_q.push_back(model(op, zv));
    tick();
    n = 0;
    while (!pc_en && n < 4) begin
      tick();
      n++;
    end
    check("exec_reached", pc_en, 1);
    e = sb_q.pop_front();
    check("ctrl", {s_inc, s_inm, we3, wez, Op}, e);
    check("exec_busy", busy, 1);
    check("ret_before", retired, exp_ret);
    halt_req = hlt;
    tick();
    halt_req = 0;
    exp_ret++;
    check("ret_after", retired, exp_ret);
    check("busy_next", busy, !hlt);
    check("pcen_next", pc_en, 0);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_outs", {s_inc, s_inm, we3, wez, Op, pc_en, busy, err}, 0);
    check("rst_ret", retired, 0);
    reset = 1;
    tick();
    check("idle_outs", {s_inc, s_inm, we3, wez, Op, pc_en, busy, err}, 0);
    start = 1;
    tick();
    start = 0;
    check("fetch_busy", busy, 1);
    check("fetch_pcen", pc_en, 0);
    check("fetch_ctrl", {s_inc, s_inm, we3, wez, Op}, 0);

    run_instr(6'b110100, 0, 0);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b000110, 1, 0);
    run_instr(6'b010000, 1, 0);
    run_instr(6'b010001, 1, 0);
    run_instr(6'b010001, 0, 0);
    run_instr(6'b010010, 1, 0);
    run_instr(6'b010010, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b100000, 0, 1);

    repeat (3) begin
      tick();
      check("halt_outs", {s_inc, s_inm, we3, wez, Op, pc_en, busy, err}, 0);
    end
    check("halt_ret", retired, exp_ret);
    start = 1;
    tick();
    start = 0;
    check("resume_fetch", {busy, pc_en}, 2'b10);

    for (int i = 0; i < 6; i++)
      run_instr(i[0] ? {1'b1, 5'($urandom_range(0, 31))} : {4'b0001, 2'($urandom_range(0, 3))}, 1'($urandom_range(0, 1)), 0);
    check("wrap", retired, 0);
    run_instr(6'b101000, 0, 0);
    check("post_wrap", retired, 1);

    // Abort an ALU instruction mid-EXEC with async reset
    Opcode = 6'b110000;
    tick();
    check("pre_abort_we3", {pc_en, we3, wez}, 3'b111);
    #2 reset = 0;
    #1;
    check("abort_ctrl", {pc_en, we3, wez}, 0);
    check("abort_ret", retired, 0);
    exp_ret = '0;
    tick();
    reset = 1;
    start = 1;
    tick();
    start = 0;
    Opcode = 6'b001100;
    tick();
    check("trap_err", err, 1);
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      halt_req = ~i[0];
      tick();
      check("trap_hold", {err, pc_en, we3, busy}, 4'b1000);
    end
    start = 0;
    halt_req = 0;
    #2 reset = 0;
    #1;
    check("trap_clear", err, 0);
    check("trap_clear_ret", retired, 0);
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
